// File: rtl/cass_pkg.sv
// Shared types and constants for the cassette-output capture block.
package cass_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HUNT = 2'd1,
        DATA = 2'd2
    } cass_state_t;

    // First byte of every block; data bytes are framed from the bit after it.
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    // Level code on io_data[1:0] that marks a cassette pulse.
    localparam logic [1:0] PULSE_CODE = 2'b01;

    // A port-FF write is a pulse only when it also keeps the motor on.
    function automatic logic is_pulse(input logic [2:0] data);
        return data[2] && (data[1:0] == PULSE_CODE);
    endfunction

endpackage

// File: rtl/cass_bit_slicer.sv
// Turns 500-baud clock/data pulses into bits. It owns the cell timer t,
// the data-pulse flag and the first-pulse flag. All outputs are combinational,
// so the top level can act on a bit in the same cycle as the pulse.
module cass_bit_slicer #(
    parameter int HALF_CELL = 1750,
    parameter int GAP_MAX   = 7000
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse,
    input  logic clear,
    output logic bit_valid,
    output logic bit_value,
    output logic gap,
    output logic dup_pulse
);

    localparam int             T_W    = $clog2(GAP_MAX + 1);
    localparam logic [T_W-1:0] T_HALF = T_W'(HALF_CELL);
    localparam logic [T_W-1:0] T_MAX  = T_W'(GAP_MAX);

    logic [T_W-1:0] t;
    logic           dflag;
    logic           first;
    logic           first_eff;
    logic           late;

    // Classify this cycle: clock pulse (emits a bit), data pulse, duplicate data pulse, or timeout.
    always_comb begin
        // NOTE: every output gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        first_eff = first || clear;
        late      = (t >= T_HALF);
        bit_valid = 1'b0;
        gap       = 1'b0;
        dup_pulse = 1'b0;
        bit_value = dflag;
        if (pulse) begin
            if (!first_eff) begin
                bit_valid = late;
                dup_pulse = !late && dflag;
            end
        end else if (!first_eff && (t == T_MAX)) begin
            // A pulse in the same cycle takes precedence over the timeout.
            gap       = 1'b1;
            bit_valid = 1'b1;
        end
    end

    // Cell timer and flags; clear restarts the capture, and a pulse arriving with it is the first clock.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            t     <= '0;
            dflag <= 1'b0;
            first <= 1'b1;
        end else if (clear) begin
            t     <= '0;
            dflag <= 1'b0;
            first <= !pulse;
        end else if (pulse && (first || late)) begin
            t     <= '0;
            dflag <= 1'b0;
            first <= 1'b0;
        end else begin
            if (t != T_MAX) begin
                t <= t + 1'b1;
            end
            if (pulse && !dflag) begin
                dflag <= 1'b1;
            end
            if (gap) begin
                first <= 1'b1;
                dflag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cass_capture.sv
// Captures port-FF cassette writes from a CSAVE as bytes and streams them
// out through a simple buffer write port.
module cass_capture
    import cass_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int HALF_CELL = 1750,
    parameter int GAP_MAX   = 7000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_wr,
    input  logic [2:0]        io_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              motor,
    output logic              synced,
    output logic              done,
    output logic              err,
    output logic              full
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    cass_state_t state;
    cass_state_t state_nxt;
    logic [7:0]  sr;
    logic [7:0]  sr_nxt;
    logic [7:0]  sr_shift;
    logic [2:0]  bitcnt;
    logic [2:0]  bitcnt_nxt;
    logic        motor_rise;
    logic        motor_fall;
    logic        pulse;
    logic        clear;
    logic        bit_valid;
    logic        bit_value;
    logic        gap;
    logic        dup_pulse;
    logic        write_req;
    logic        done_nxt;
    logic        full_now;

    // Decode motor edges and pulses; the motor is handled first, so a falling write never counts as a pulse.
    always_comb begin
        motor_rise = io_wr && io_data[2] && !motor;
        motor_fall = io_wr && !io_data[2] && motor;
        pulse      = io_wr && is_pulse(io_data);
        clear      = motor_rise || motor_fall;
    end

    cass_bit_slicer #(
        .HALF_CELL (HALF_CELL),
        .GAP_MAX   (GAP_MAX)
    ) u_slicer (
        .clk       (clk),
        .reset     (reset),
        .pulse     (pulse),
        .clear     (clear),
        .bit_valid (bit_valid),
        .bit_value (bit_value),
        .gap       (gap),
        .dup_pulse (dup_pulse)
    );

    // Next state: shift in each bit, hunt for the sync byte, frame bytes, end the block on a gap.
    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        bitcnt_nxt = bitcnt;
        write_req  = 1'b0;
        done_nxt   = 1'b0;
        sr_shift   = {sr[6:0], bit_value};
        if (motor_rise) begin
            state_nxt  = HUNT;
            sr_nxt     = '0;
            bitcnt_nxt = '0;
        end else if (motor_fall) begin
            // A partially assembled byte is dropped here.
            state_nxt  = OFF;
            sr_nxt     = '0;
            bitcnt_nxt = '0;
        end else if (bit_valid && (state != OFF)) begin
            sr_nxt = sr_shift;
            case (state)
                HUNT: begin
                    if (sr_shift == SYNC_BYTE) begin
                        write_req  = 1'b1;
                        state_nxt  = DATA;
                        bitcnt_nxt = '0;
                    end
                end
                DATA: begin
                    bitcnt_nxt = bitcnt + 3'd1;
                    write_req  = (bitcnt == 3'd7);
                end
                default: begin
                end
            endcase
            // Gap closes the block; the address is kept so the next block appends.
            if (gap && ((state == DATA) || (state_nxt == DATA))) begin
                state_nxt = HUNT;
                done_nxt  = 1'b1;
            end
        end
    end

    // State register, shift register and latched motor bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= OFF;
            sr     <= '0;
            bitcnt <= '0;
            motor  <= 1'b0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            bitcnt <= bitcnt_nxt;
            if (io_wr) begin
                motor <= io_data[2];
            end
        end
    end

    // The last slot counts as used in the cycle it is written, before full has registered.
    assign full_now = full || (wr_en && (wr_addr == ADDR_LAST));
    assign synced   = (state == DATA);

    // Write port: issue the byte at the current address, then advance the address or saturate into full.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            full    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= done_nxt;
            if (motor_rise) begin
                wr_addr <= '0;
                err     <= 1'b0;
                full    <= 1'b0;
            end else begin
                if (wr_en) begin
                    if (wr_addr == ADDR_LAST) begin
                        full <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                if (dup_pulse) begin
                    err <= 1'b1;
                end
                if (write_req && !full_now) begin
                    wr_en   <= 1'b1;
                    wr_data <= sr_shift;
                end
            end
        end
    end

endmodule

// File: tb/tb_cass_capture.sv
// Randomized bench for cass_capture. Two instances share the stimulus: a
// large buffer and a 4-entry buffer, so buffer-full behaviour is seen
// alongside normal capture. Expected writes come from a cell-level model:
// each cell carries one bit; the bit list of a block is scanned for the sync
// byte and the rest is cut into bytes.
module tb_cass_capture;
    import cass_pkg::*;

    localparam int HC       = 16;
    localparam int GM       = 64;
    localparam int CELL     = 32;
    localparam int AW_BIG   = 14;
    localparam int AW_SMALL = 2;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       io_wr   = 1'b0;
    logic [2:0] io_data = 3'b000;

    logic              b_wr_en, b_motor, b_synced, b_done, b_err, b_full;
    logic [AW_BIG-1:0] b_wr_addr;
    logic [7:0]        b_wr_data;
    logic                s_wr_en, s_motor, s_synced, s_done, s_err, s_full;
    logic [AW_SMALL-1:0] s_wr_addr;
    logic [7:0]          s_wr_data;

    cass_capture #(.ADDR_W(AW_BIG), .HALF_CELL(HC), .GAP_MAX(GM)) u_big (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_data(io_data),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .motor(b_motor),
        .synced(b_synced), .done(b_done), .err(b_err), .full(b_full)
    );

    cass_capture #(.ADDR_W(AW_SMALL), .HALF_CELL(HC), .GAP_MAX(GM)) u_small (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_data(io_data),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .motor(s_motor),
        .synced(s_synced), .done(s_done), .err(s_err), .full(s_full)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed traffic, recorded away from the active edge.
    wr_t b_act[$];
    wr_t s_act[$];
    int  b_done_cyc[$];
    int  s_done_n = 0;

    always @(negedge clk) begin
        if (b_wr_en) b_act.push_back({16'(b_wr_addr), b_wr_data});
        if (s_wr_en) s_act.push_back({16'(s_wr_addr), s_wr_data});
        if (b_done) b_done_cyc.push_back(cyc);
        if (s_done) s_done_n++;
    end

    // Reference model state.
    wr_t  b_exp[$];
    wr_t  s_exp[$];
    int   exp_done_cyc[$];
    logic blk_bits[$];
    int   stored        = 0;
    logic exp_err       = 1'b0;
    logic pend_valid    = 1'b0;
    logic pend_bit      = 1'b0;
    int   last_clk_edge = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wr_cycle(input logic en, input logic [2:0] d);
        @(negedge clk);
        io_wr   = en;
        io_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) wr_cycle(1'b0, io_data);
    endtask

    task automatic model_restart();
        stored     = 0;
        exp_err    = 1'b0;
        pend_valid = 1'b0;
        blk_bits.delete();
    endtask

    task automatic motor_on();
        wr_cycle(1'b1, 3'b100);
        model_restart();
    endtask

    // One 32-cycle cell: clock pulse at offset 0, data pulse at doff for a 1
    // (and a second one three cycles later when dbl is set).
    task automatic send_cell(input logic bitv, input int doff, input logic dbl);
        wr_cycle(1'b1, 3'b101);
        last_clk_edge = cyc + 1;
        if (pend_valid) blk_bits.push_back(pend_bit);
        for (int k = 1; k < CELL; k++) begin
            wr_cycle(bitv && ((k == doff) || (dbl && (k == doff + 3))), 3'b101);
        end
        pend_valid = 1'b1;
        pend_bit   = bitv;
        if (dbl) exp_err = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] dmask);
        for (int i = 7; i >= 0; i--) begin
            send_cell(b[i], int'($urandom_range(4, 12)), b[i] & dmask[i]);
        end
    endtask

    task automatic send_leader(input int n);
        for (int i = 0; i < n; i++) send_cell(1'b0, 8, 1'b0);
    endtask

    task automatic expect_write(input logic [7:0] b);
        wr_t e;
        e.addr = 16'(stored);
        e.data = b;
        if (stored < (1 << AW_BIG)) b_exp.push_back(e);
        if (stored < (1 << AW_SMALL)) s_exp.push_back(e);
        stored++;
    endtask

    function automatic logic [7:0] window(input int last);
        logic [7:0] w;
        for (int k = 0; k < 8; k++) w[7 - k] = blk_bits[last - 7 + k];
        return w;
    endfunction

    // Find the sync byte in the block's bits; every full 8 bits after it is a byte.
    task automatic process_block(input logic is_gap);
        int sync_end = -1;
        int nbytes;
        for (int i = 7; i < blk_bits.size() && sync_end < 0; i++) begin
            if (window(i) == 8'hA5) sync_end = i;
        end
        if (sync_end >= 0) begin
            expect_write(8'hA5);
            nbytes = (blk_bits.size() - 1 - sync_end) / 8;
            for (int j = 0; j < nbytes; j++) expect_write(window(sync_end + 8 * (j + 1)));
            if (is_gap) exp_done_cyc.push_back(last_clk_edge + GM + 1);
        end
        blk_bits.delete();
    endtask

    // Silence long enough for the timeout; the last cell's bit is released by it.
    task automatic gap_end();
        idle(GM + 20);
        if (pend_valid) blk_bits.push_back(pend_bit);
        pend_valid = 1'b0;
        process_block(1'b1);
    endtask

    // Motor off with the pulse level code in the same write: the level must be ignored.
    task automatic motor_off();
        wr_cycle(1'b1, 3'b001);
        pend_valid = 1'b0;
        process_block(1'b0);
        idle(4);
    endtask

    task automatic compare_writes(input string tag);
        check($sformatf("%s_nwr_big", tag), 32'(b_act.size()), 32'(b_exp.size()));
        for (int i = 0; i < b_act.size() && i < b_exp.size(); i++) begin
            check($sformatf("%s_big_wr%0d", tag, i), 32'(b_act[i]), 32'(b_exp[i]));
        end
        check($sformatf("%s_nwr_small", tag), 32'(s_act.size()), 32'(s_exp.size()));
        for (int i = 0; i < s_act.size() && i < s_exp.size(); i++) begin
            check($sformatf("%s_small_wr%0d", tag, i), 32'(s_act[i]), 32'(s_exp[i]));
        end
        check($sformatf("%s_ndone_big", tag), 32'(b_done_cyc.size()), 32'(exp_done_cyc.size()));
        for (int i = 0; i < b_done_cyc.size() && i < exp_done_cyc.size(); i++) begin
            check($sformatf("%s_done_cyc%0d", tag, i), 32'(b_done_cyc[i]), 32'(exp_done_cyc[i]));
        end
        check($sformatf("%s_ndone_small", tag), 32'(s_done_n), 32'(exp_done_cyc.size()));
        b_act.delete();
        s_act.delete();
        b_exp.delete();
        s_exp.delete();
        b_done_cyc.delete();
        exp_done_cyc.delete();
        s_done_n = 0;
    endtask

    task automatic check_status(input string tag, input logic exp_synced, input logic exp_motor);
        int small_addr;
        small_addr = (stored >= (1 << AW_SMALL)) ? (1 << AW_SMALL) - 1 : stored;
        check({tag, "_motor"}, 32'(b_motor), 32'(exp_motor));
        check({tag, "_synced"}, 32'(b_synced), 32'(exp_synced));
        check({tag, "_err_big"}, 32'(b_err), 32'(exp_err));
        check({tag, "_err_small"}, 32'(s_err), 32'(exp_err));
        check({tag, "_addr_big"}, 32'(b_wr_addr), 32'(stored));
        check({tag, "_addr_small"}, 32'(s_wr_addr), 32'(small_addr));
        check({tag, "_full_big"}, 32'(b_full), 32'(stored >= (1 << AW_BIG)));
        check({tag, "_full_small"}, 32'(s_full), 32'(stored >= (1 << AW_SMALL)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_big"}, 32'({b_wr_en, b_wr_addr, b_wr_data, b_motor, b_synced, b_done, b_err, b_full}), 32'd0);
        check({tag, "_small"}, 32'({s_wr_en, s_wr_addr, s_wr_data, s_motor, s_synced, s_done, s_err, s_full}), 32'd0);
        check({tag, "_state"}, 32'(u_big.state), 32'(OFF));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        logic [7:0] b;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Sync and data: A5@0, 3C@1, done with the gap-emitted byte.
        motor_on();
        send_leader(16);
        send_byte(8'hA5, 8'h00);
        send_byte(8'h3C, 8'h00);
        gap_end();
        compare_writes("sync");
        check_status("sync", 1'b0, 1'b1);

        // Leader only: no sync, no writes, no done.
        motor_off();
        motor_on();
        send_leader(64);
        gap_end();
        compare_writes("leader");
        check_status("leader", 1'b0, 1'b1);

        // Random captures, two blocks each; the second block appends.
        for (int rep = 0; rep < 3; rep++) begin
            motor_off();
            motor_on();
            for (int blk = 0; blk < 2; blk++) begin
                send_leader(int'($urandom_range(10, 20)));
                send_byte(8'hA5, 8'h00);
                nb = int'($urandom_range(1, 4));
                for (int i = 0; i < nb; i++) send_byte(8'($urandom), 8'h00);
                gap_end();
                compare_writes($sformatf("rand%0d_%0d", rep, blk));
                check_status($sformatf("rand%0d_%0d", rep, blk), 1'b0, 1'b1);
            end
        end

        // Double data pulse in one cell: err set, bit still read as 1.
        motor_off();
        motor_on();
        send_leader(12);
        send_byte(8'hA5, 8'h00);
        b = 8'h80 | 8'($urandom);
        send_byte(b, 8'h80);
        gap_end();
        compare_writes("dbl");
        check_status("dbl", 1'b0, 1'b1);
        motor_off();
        motor_on();
        idle(3);
        check_status("dbl_clr", 1'b0, 1'b1);

        // Motor off mid-byte: partial byte dropped, no done.
        send_leader(12);
        send_byte(8'hA5, 8'h00);
        for (int i = 0; i < 5; i++) send_cell(1'($urandom), int'($urandom_range(4, 12)), 1'b0);
        check("mid_synced", 32'(b_synced), 32'd1);
        motor_off();
        compare_writes("moff");
        check_status("moff", 1'b0, 1'b0);
        check("moff_state", 32'(u_big.state), 32'(OFF));

        // Buffer full on the 4-entry instance.
        motor_on();
        send_leader(12);
        send_byte(8'hA5, 8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 8'h00);
        gap_end();
        compare_writes("full");
        check_status("full", 1'b0, 1'b1);

        // Reset in the middle of DATA.
        motor_off();
        motor_on();
        send_leader(12);
        send_byte(8'hA5, 8'h00);
        for (int i = 0; i < 3; i++) send_cell(1'($urandom), int'($urandom_range(4, 12)), 1'b0);
        check("rst_pre_synced", 32'(b_synced), 32'd1);
        @(negedge clk);
        io_wr = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("rst_mid");
        reset = 1'b0;
        pend_valid = 1'b0;
        process_block(1'b0);
        compare_writes("rst_pre");
        model_restart();
        wr_cycle(1'b1, 3'b001);
        idle(GM + 20);
        compare_writes("rst_post");
        check_all_zero("rst_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
